// File: rtl/d_ff_ple.sv
// d_ff_ple: positive-level-enable storage bank built from flops only.
// While le is high the bank loads d every clock (and, in transparent
// mode, q follows d combinationally); while le is low it holds.
module d_ff_ple #(
    parameter int WIDTH       = 1,
    parameter int TRANSPARENT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             le,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             loaded
);

    logic [WIDTH-1:0] store_q;
    logic [WIDTH-1:0] store_d;
    logic             loaded_q;
    logic             loaded_d;

    // Next-state: load d and mark loaded while le is high, otherwise hold.
    always_comb begin
        store_d  = store_q;
        loaded_d = loaded_q;
        if (le) begin
            store_d  = d;
            loaded_d = 1'b1;
        end
    end

    // State register; synchronous reset wins over any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            store_q  <= store_d;
            loaded_q <= loaded_d;
        end
    end

    assign loaded = loaded_q;

    // Output path chosen at elaboration: a reset-gated 2:1 mux for
    // transparent mode, the plain register for registered mode.
    generate
        if (TRANSPARENT == 1) begin : g_transparent
            assign q = rst ? '0 : (le ? d : store_q);
        end else begin : g_registered
            assign q = store_q;
        end
    endgenerate

    // Reject parameter values outside the supported range at elaboration.
    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("d_ff_ple: WIDTH must be within 1..64");
        end
        if (TRANSPARENT != 0 && TRANSPARENT != 1) begin : g_bad_transparent
            $error("d_ff_ple: TRANSPARENT must be 0 or 1");
        end
    endgenerate

endmodule

// File: tb/tb_d_ff_ple.sv
// Directed testbench for d_ff_ple: a 1-bit transparent bank, an 8-bit
// registered bank and an 8-bit transparent bank share clock and reset.
module tb_d_ff_ple;

    logic       clk;
    logic       rst;
    logic       leT;
    logic       dT;
    logic       qT;
    logic       loadedT;
    logic       leR;
    logic [7:0] dR;
    logic [7:0] qR;
    logic       loadedR;
    logic       le8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic       loaded8;

    int vectors;
    int miscompares;

    d_ff_ple #(.WIDTH(1), .TRANSPARENT(1)) uT1 (
        .clk(clk), .rst(rst), .le(leT), .d(dT), .q(qT), .loaded(loadedT)
    );

    d_ff_ple #(.WIDTH(8), .TRANSPARENT(0)) uR8 (
        .clk(clk), .rst(rst), .le(leR), .d(dR), .q(qR), .loaded(loadedR)
    );

    d_ff_ple #(.WIDTH(8), .TRANSPARENT(1)) uT8 (
        .clk(clk), .rst(rst), .le(le8), .d(d8), .q(q8), .loaded(loaded8)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the 1-bit transparent bank and let the mux settle.
    task automatic applyStimulus(input logic le, input logic d);
        leT = le;
        dT  = d;
        #1;
    endtask

    // One comparison point: count it, and report any miscompare.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset held for two cycles while every bank is asked to load.
        rst = 1'b1;
        leT = 1'b1;
        dT  = 1'b1;
        leR = 1'b1;
        dR  = 8'hA5;
        le8 = 1'b1;
        d8  = 8'hFF;
        tick();
        tick();
        checkOutput("rst_t1_q", 64'(qT), 64'h0);
        checkOutput("rst_t1_loaded", 64'(loadedT), 64'h0);
        checkOutput("rst_r8_q", 64'(qR), 64'h0);
        checkOutput("rst_r8_loaded", 64'(loadedR), 64'h0);
        checkOutput("rst_t8_q", 64'(q8), 64'h0);
        checkOutput("rst_t8_loaded", 64'(loaded8), 64'h0);

        // Release reset with le high: transparent banks pass d at once,
        // nothing is marked loaded until the following edge.
        rst = 1'b0;
        #1;
        checkOutput("rel_t1_q_comb", 64'(qT), 64'h1);
        checkOutput("rel_t1_loaded_pre", 64'(loadedT), 64'h0);
        checkOutput("rel_r8_q_pre", 64'(qR), 64'h0);
        checkOutput("rel_t8_q_comb", 64'(q8), 64'hFF);
        tick();
        checkOutput("rel_t1_q", 64'(qT), 64'h1);
        checkOutput("rel_t1_loaded", 64'(loadedT), 64'h1);
        checkOutput("reg_r8_q_lat1", 64'(qR), 64'hA5);
        checkOutput("reg_r8_loaded", 64'(loadedR), 64'h1);
        checkOutput("rel_t8_loaded", 64'(loaded8), 64'h1);

        // Registered bank holds 0xA5 for ten cycles while d changes;
        // the 8-bit transparent bank starts holding 0xFF.
        leR = 1'b0;
        dR  = 8'h3C;
        le8 = 1'b0;
        d8  = 8'h00;
        #1;
        checkOutput("hold_t8_q_comb", 64'(q8), 64'hFF);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("hold_r8_q", 64'(qR), 64'hA5);
        end
        checkOutput("hold_t8_q", 64'(q8), 64'hFF);

        // Reset in the middle of a hold: outputs go to zero immediately
        // in transparent mode, and loaded clears on the edge.
        rst = 1'b1;
        leT = 1'b0;
        dT  = 1'b0;
        #1;
        checkOutput("midrst_t8_q_comb", 64'(q8), 64'h0);
        checkOutput("midrst_t1_q_comb", 64'(qT), 64'h0);
        tick();
        checkOutput("midrst_t8_loaded", 64'(loaded8), 64'h0);
        checkOutput("midrst_r8_q", 64'(qR), 64'h0);
        checkOutput("midrst_r8_loaded", 64'(loadedR), 64'h0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_t8_q", 64'(q8), 64'h0);
        checkOutput("post_rst_t8_loaded", 64'(loaded8), 64'h0);

        // Transparency sequence on the 1-bit bank, one step per clock.
        checkOutput("tr_le0_d0", 64'(qT), 64'h0);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("tr_le1_d0_a", 64'(qT), 64'h0);
        tick();
        applyStimulus(1'b1, 1'b1);
        checkOutput("tr_le1_d1_a", 64'(qT), 64'h1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("tr_le1_d0_b", 64'(qT), 64'h0);
        tick();
        applyStimulus(1'b1, 1'b1);
        checkOutput("tr_le1_d1_b", 64'(qT), 64'h1);
        tick();

        // Hold what was captured, ignore d, then reopen transparently.
        applyStimulus(1'b0, 1'b0);
        checkOutput("hold_le0_d0", 64'(qT), 64'h1);
        tick();
        applyStimulus(1'b0, 1'b1);
        checkOutput("hold_le0_d1", 64'(qT), 64'h1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("reopen_le1_d0", 64'(qT), 64'h0);
        tick();
        checkOutput("t8_still_zero", 64'(q8), 64'h0);

        // Capture 1, then drop le and change d in the same cycle.
        applyStimulus(1'b1, 1'b1);
        checkOutput("simul_capture", 64'(qT), 64'h1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("simul_hold_comb", 64'(qT), 64'h1);
        tick();
        checkOutput("simul_hold_edge", 64'(qT), 64'h1);
        checkOutput("simul_loaded", 64'(loadedT), 64'h1);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
